// File: rtl/pst_if_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, NOP word, fetch entry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pst_if_pkg;

  localparam int IF_ST_BIT = 1;

  typedef enum logic [IF_ST_BIT-1:0] {
    IF_ST_RUN  = 1'b0,
    IF_ST_HALT = 1'b1
  } if_st_e;

  localparam logic [31:0] INST_NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DFLT = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_ent_t;

endpackage

// File: rtl/pst_if_if.sv
// Fetch-to-Decode instruction bus: instruction, its pc, pc+4, valid, stall.
// Latency: n/a (wires only).
// Backpressure: Decode raises stall; Fetch holds inst/pc/pc_4/inst_valid.
interface pst_if_if;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        inst_valid;
  logic        stall;

  modport master (output inst, output pc, output pc_4, output inst_valid, input stall);
  modport slave  (input inst, input pc, input pc_4, input inst_valid, output stall);
endinterface

// File: rtl/pst_if_skid_buf.sv
// One-entry {inst, pc} holding register catching a ROM read the output cannot take.
// Latency: 1 cycle from load to vld.
// Backpressure: none internally; load has priority over clr in the same cycle.
module if_skid_buf
  import pst_if_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    clr,
  input  if_ent_t din,
  output logic    vld,
  output if_ent_t dout
);

  // Load captures a new entry; clear drops the entry once it has moved out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (clr) begin
      vld  <= 1'b0;
      dout <= '0;
    end
  end

endmodule

// File: rtl/pst_if.sv
// Instruction fetch: PC, sync-ROM issue, output register + 1-entry skid to Decode.
// Latency: ROM read arrives 1 cycle after im_en; first inst_valid at the 2nd enabled edge.
// Backpressure: issue only while output+skid+inflight has room, so a stall never drops a read.
module pst_if
  import pst_if_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DFLT,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic             im_en,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  pst_if_if.master         dec
);

  if_st_e      state_q, state_d;
  logic [31:0] pc_fetch;
  logic [31:0] issue_pc;
  logic        inflight;

  logic        out_vld;
  if_ent_t     out_q;
  logic [31:0] out_pc4;

  logic        skid_vld;
  if_ent_t     skid_q;
  logic        skid_load;
  logic        skid_clr;

  logic        run;
  logic        flush;
  logic        consume;
  logic        out_free;
  logic [1:0]  cnt;
  if_ent_t     arr;
  logic [31:0] tgt_pc;

  assign run      = (state_q == IF_ST_RUN);
  assign consume  = out_vld & ~dec.stall;
  assign out_free = ~out_vld | consume;
  assign cnt      = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, inflight};
  assign flush    = en & (halt | (run & redirect));
  assign arr      = '{inst: im_data, pc: issue_pc};
  assign tgt_pc   = redirect_pc & ~32'h3;
  assign im_addr  = pc_fetch[IM_AW+1:2];

  // Next state and issue strobe; halt is sticky until reset.
  always_comb begin
    state_d = state_q;
    im_en   = 1'b0;
    if (en && halt) state_d = IF_ST_HALT;
    if (en && run && !redirect && !halt && ((cnt - {1'b0, consume}) < 2'd2)) im_en = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IF_ST_RUN;
    else if (en) state_q <= state_d;
  end

  // Fetch PC, address of the read in flight, and the in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_fetch <= PC_RESET;
      issue_pc <= PC_RESET;
      inflight <= 1'b0;
    end else if (en) begin
      inflight <= im_en;
      if (run && redirect && !halt) begin
        pc_fetch <= tgt_pc;
      end else if (im_en) begin
        pc_fetch <= pc_fetch + 32'd4;
        issue_pc <= pc_fetch;
      end
    end
  end

  // Arrivals go to the skid when the output is busy or older data already waits there.
  assign skid_load = en & ~flush & inflight & (~out_free | skid_vld);
  assign skid_clr  = en & (flush | (out_free & skid_vld));

  if_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clr   (skid_clr),
    .din   (arr),
    .vld   (skid_vld),
    .dout  (skid_q)
  );

  // Output register always holds the oldest instruction: skid first, then arrival, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_q   <= '{inst: INST_NOP, pc: 32'h0};
      out_pc4 <= 32'h0;
    end else if (en) begin
      if (flush) begin
        out_vld <= 1'b0;
        out_q   <= '{inst: INST_NOP, pc: 32'h0};
        out_pc4 <= 32'h0;
      end else if (out_free) begin
        if (skid_vld) begin
          out_vld <= 1'b1;
          out_q   <= skid_q;
          out_pc4 <= skid_q.pc + 32'd4;
        end else if (inflight) begin
          out_vld <= 1'b1;
          out_q   <= arr;
          out_pc4 <= arr.pc + 32'd4;
        end else begin
          out_vld <= 1'b0;
          out_q   <= '{inst: INST_NOP, pc: 32'h0};
          out_pc4 <= 32'h0;
        end
      end
    end
  end

  assign dec.inst       = out_q.inst;
  assign dec.pc         = out_q.pc;
  assign dec.pc_4       = out_pc4;
  assign dec.inst_valid = out_vld;

endmodule

// File: tb/tb_pst_if.sv
module tb_pst_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        im_en;
  logic [9:0]  im_addr;
  logic [31:0] im_data = 32'h0;

  logic [31:0] rom [0:1023];

  int checks   = 0;
  int failures = 0;

  pst_if_if dec_bus ();

  pst_if #(.PC_RESET(32'h0), .IM_AW(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .im_en       (im_en),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .dec         (dec_bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model, 1-cycle read, data held between reads.
  always @(posedge clk) begin
    if (im_en) im_data <= rom[im_addr];
  end

  typedef struct {
    bit          en;
    bit          stall;
    bit          redir;
    bit          halt;
    logic [31:0] rpc;
    bit          exp_im;
    logic [9:0]  exp_addr;
    bit          exp_vld;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit e, bit s, bit r, bit h, logic [31:0] rp,
                              bit im, logic [9:0] ad, bit v, logic [31:0] ins, logic [31:0] p);
    vec_t t;
    t.en = e; t.stall = s; t.redir = r; t.halt = h; t.rpc = rp;
    t.exp_im = im; t.exp_addr = ad; t.exp_vld = v; t.exp_inst = ins; t.exp_pc = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check the issue strobe before the
  // rising edge and the registered outputs just after it.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    en              = t.en;
    dec_bus.stall   = t.stall;
    redirect        = t.redir;
    halt            = t.halt;
    redirect_pc     = t.rpc;
    #1;
    chk({tag, "_im_en"}, {31'h0, im_en}, {31'h0, t.exp_im});
    if (t.exp_im) chk({tag, "_im_addr"}, {22'h0, im_addr}, {22'h0, t.exp_addr});
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {31'h0, dec_bus.inst_valid}, {31'h0, t.exp_vld});
    if (t.exp_vld) begin
      chk({tag, "_inst"}, dec_bus.inst, t.exp_inst);
      chk({tag, "_pc"},   dec_bus.pc,   t.exp_pc);
      chk({tag, "_pc4"},  dec_bus.pc_4, t.exp_pc + 32'd4);
    end else begin
      chk({tag, "_nop"}, dec_bus.inst, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = i + 32'h100;

    //            en st rd ht rpc            im addr    vld inst        pc
    // stream from reset
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd1,   1, 32'h100,   32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd2,   1, 32'h101,   32'h4));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd3,   1, 32'h102,   32'h8));
    // stall 3 cycles at pc 8, skid absorbs 0x103
    tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 10'd0,   1, 32'h102,   32'h8));
    tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 10'd0,   1, 32'h102,   32'h8));
    tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 10'd0,   1, 32'h102,   32'h8));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd4,   1, 32'h103,   32'hC));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd5,   1, 32'h104,   32'h10));
    // redirect to 0x43 (low bits ignored)
    tv.push_back(mk(1, 0, 1, 0, 32'h43,       0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd16,  0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd17,  1, 32'h110,   32'h40));
    // stall fills skid, then redirect+stall together
    tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 10'd0,   1, 32'h110,   32'h40));
    tv.push_back(mk(1, 1, 1, 0, 32'h80,       0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd32,  0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd33,  1, 32'h120,   32'h80));
    // en low 4 cycles: frozen
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0, 0, 0, 0, 32'h0,      0, 10'd0,   1, 32'h120,   32'h80));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd34,  1, 32'h121,   32'h84));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd35,  1, 32'h122,   32'h88));
    // ROM address wrap
    tv.push_back(mk(1, 0, 1, 0, 32'hFFC,      0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'h3FF, 0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd0,   1, 32'h4FF,   32'hFFC));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd1,   1, 32'h100,   32'h1000));
    // 32-bit pc wrap
    tv.push_back(mk(1, 0, 1, 0, 32'hFFFF_FFFC, 0, 10'd0,  0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'h3FF, 0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd0,   1, 32'h4FF,   32'hFFFF_FFFC));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        1, 10'd1,   1, 32'h100,   32'h0));
    // halt, then redirect ignored in HALT
    tv.push_back(mk(1, 0, 0, 1, 32'h0,        0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 1, 0, 32'h40,       0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 10'd0,   0, 32'h0,     32'h0));
    tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 10'd0,   0, 32'h0,     32'h0));

    // Reset state
    rst_n = 1'b0; en = 1'b0; redirect = 1'b0; halt = 1'b0;
    redirect_pc = 32'h0; dec_bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst", dec_bus.inst, 32'h0);
    chk("rst_pc",   dec_bus.pc,   32'h0);
    chk("rst_pc4",  dec_bus.pc_4, 32'h0);
    chk("rst_vld",  {31'h0, dec_bus.inst_valid}, 32'h0);
    chk("rst_im_en", {31'h0, im_en}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (tv[i]) apply(tv[i], $sformatf("v%0d", i));

    // Reset asserted mid-HALT: back to PC_RESET and fetching again
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("hrst_vld",   {31'h0, dec_bus.inst_valid}, 32'h0);
    chk("hrst_im_en", {31'h0, im_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 0, 0, 32'h0, 1, 10'd0, 0, 32'h0,   32'h0), "hrst0");
    apply(mk(1, 0, 0, 0, 32'h0, 1, 10'd1, 1, 32'h100, 32'h0), "hrst1");
    apply(mk(1, 0, 0, 0, 32'h0, 1, 10'd2, 1, 32'h101, 32'h4), "hrst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
